sonar_scheduler: RTL

//  Sequences three ultrasonic sonars (HC-SR04 style) round-robin, sharing one echo-width

---
 rtl/sonar_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sonar_scheduler.sv
// Round-robin sequencer for three HC-SR04 style sonars sharing one echo timer.
// Each sensor is triggered, its echo width is timed in microseconds, and the result
// is handed to the serial formatter over valid/ready. A pronto pulse marks each
// completed round of three sensors.
module sonar_scheduler #(
  parameter int CLK_PER_US = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 60000,
  parameter int W          = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ligar,
  input  logic [2:0]   echo,
  output logic [2:0]   trigger,
  output logic         med_valid,
  input  logic         med_ready,
  output logic [1:0]   med_sensor,
  output logic [W-1:0] med_us,
  output logic         med_timeout,
  output logic         pronto,
  output logic [3:0]   db_estado
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    TRIG      = 4'd1,
    WAIT_ECHO = 4'd2,
    MEASURE   = 4'd3,
    SEND      = 4'd4,
    NEXT      = 4'd5,
    GAP       = 4'd6
  } state_t;

  // prescaler width; guarded so a 1-cycle microsecond still gets a 1-bit counter
  localparam int PW    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int CMAX0 = (GAP_US > TIMEOUT_US) ? GAP_US : TIMEOUT_US;
  localparam int CMAX  = (CMAX0 > TRIG_US) ? CMAX0 : TRIG_US;
  localparam int CW    = $clog2(CMAX + 2) + 1;
  // a measurement saturates at whichever comes first: timeout or all-ones
  localparam int LIM   = (TIMEOUT_US < (2**W - 1)) ? TIMEOUT_US : (2**W - 1);

  localparam logic [PW-1:0] C_PRE_END  = PW'(CLK_PER_US - 1);
  localparam logic [CW-1:0] C_TRIG_END = CW'(TRIG_US - 1);
  localparam logic [CW-1:0] C_TO_END   = CW'(TIMEOUT_US - 1);
  localparam logic [CW-1:0] C_GAP_END  = CW'(GAP_US - 1);
  localparam logic [CW-1:0] C_LIM      = CW'(LIM);

  state_t         r_state, w_state_n;
  logic [1:0]     r_idx, w_idx_n;
  logic [PW-1:0]  r_pre;
  logic [CW-1:0]  r_us;
  logic [2:0]     r_s1, r_s2, r_s3;
  logic [2:0]     r_trig;
  logic           r_valid, r_pronto, r_med_to;
  logic [1:0]     r_med_sensor;
  logic [W-1:0]   r_med_us;
  logic [W-1:0]   w_us_n;
  logic           w_to_n;
  logic           w_tick, w_rise, w_fall;
  logic [CW-1:0]  w_cnt;

  assign w_tick = (r_pre == C_PRE_END);
  // completed microseconds including one that completes this very cycle
  assign w_cnt  = r_us + {{(CW-1){1'b0}}, w_tick};
  // only the active sensor's echo is looked at; the others are ignored
  assign w_rise = r_s2[r_idx] & ~r_s3[r_idx];
  assign w_fall = ~r_s2[r_idx] & r_s3[r_idx];

  // two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= echo;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // next-state, next sensor index and the measurement captured on entering SEND
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_us_n    = r_med_us;
    w_to_n    = r_med_to;
    case (r_state)
      IDLE: if (ligar) begin
        w_state_n = TRIG;
        w_idx_n   = 2'd0;
      end
      TRIG: if (w_tick && r_us == C_TRIG_END) w_state_n = WAIT_ECHO;
      WAIT_ECHO: begin
        if (w_rise) begin
          w_state_n = MEASURE;
        end else if (w_tick && r_us == C_TO_END) begin
          w_state_n = SEND;
          w_us_n    = '1;
          w_to_n    = 1'b1;
        end
      end
      MEASURE: begin
        // a fall wins over saturation in the same cycle
        if (w_fall) begin
          w_state_n = SEND;
          w_us_n    = W'(w_cnt);
          w_to_n    = 1'b0;
        end else if (w_cnt >= C_LIM) begin
          w_state_n = SEND;
          w_us_n    = '1;
          w_to_n    = 1'b1;
        end
      end
      SEND: if (med_ready) w_state_n = NEXT;
      NEXT: begin
        if (r_idx == 2'd2) begin
          w_idx_n   = 2'd0;
          w_state_n = GAP;
        end else begin
          w_idx_n   = r_idx + 2'd1;
          w_state_n = TRIG;
        end
      end
      GAP: if (w_tick && r_us == C_GAP_END) w_state_n = ligar ? TRIG : IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // state and sensor index registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
    end
  end

  // shared microsecond timer, restarted on every state change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_us  <= '0;
    end else if (w_state_n != r_state) begin
      r_pre <= '0;
      r_us  <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_us  <= r_us + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // outputs registered from the next state so they line up with the state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_trig       <= '0;
      r_valid      <= 1'b0;
      r_pronto     <= 1'b0;
      r_med_sensor <= '0;
      r_med_us     <= '0;
      r_med_to     <= 1'b0;
    end else begin
      r_trig   <= (w_state_n == TRIG) ? (3'b001 << w_idx_n) : 3'b000;
      r_valid  <= (w_state_n == SEND);
      r_pronto <= (r_state == NEXT) && (w_state_n == GAP);
      if (w_state_n == SEND && r_state != SEND) begin
        r_med_sensor <= r_idx;
        r_med_us     <= w_us_n;
        r_med_to     <= w_to_n;
      end
    end
  end

  assign trigger     = r_trig;
  assign med_valid   = r_valid;
  assign med_sensor  = r_med_sensor;
  assign med_us      = r_med_us;
  assign med_timeout = r_med_to;
  assign pronto      = r_pronto;
  assign db_estado   = r_state;

endmodule
